mux_serializer: RTL

- Upstream sequencing stage for the 8:1 selector: accepts an 8-bit word over a valid/ready handshake, then steps a 3-bit select through all eight positions.
- Emits one selected bit per accepted output beat.
- Exports the live word and select so an external multiplexor3 instance can be driven in parallel and cross-checked.
- Sits between a byte producer and a 1-bit serial consumer.

---
 rtl/mux_serializer.sv | 102 ++++++++++
 1 files changed

// File: rtl/mux_serializer.sv
// mux_serializer: accepts an 8-bit word on a valid/ready input port and
// replays it one bit per output beat by stepping a 3-bit select through all
// eight positions. The live word and select are exported so an external 8:1
// selector can be driven in parallel and cross-checked against out_bit.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. A source holding valid keeps its
// payload stable until that transfer. out_valid never drops without a
// transfer. in_ready depends combinationally on out_ready, so a new word can
// be taken on the same edge that retires the last beat of the previous one.
module mux_serializer #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] word,
  output logic [2:0]       sel,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  // First and final bit index of a frame, set by the serialization order.
  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] word_next;
  logic [2:0]       sel_next;
  logic             beat_done;

  // Output decode: valid/busy follow the state; out_bit is a plain mux tap.
  always_comb begin
    out_valid = (state == SHIFT);
    busy      = (state == SHIFT);
    out_bit   = word[sel];
    out_last  = out_valid && (sel == END_IDX);
    beat_done = out_valid && out_ready;
    in_ready  = (state == IDLE) || (beat_done && out_last);
  end

  // Next-state logic: load, step, reload back-to-back, or drop to idle.
  always_comb begin
    state_next = state;
    word_next  = word;
    sel_next   = sel;
    case (state)
      IDLE: begin
        if (in_valid) begin
          word_next  = in_data;
          sel_next   = START_IDX;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_done) begin
          if (sel != END_IDX) begin
            // Mid-frame: step toward the end index; the word is untouched.
            sel_next = MSB_FIRST ? (sel - 3'd1) : (sel + 3'd1);
          end else if (in_valid) begin
            // Frame end with a word waiting: reload with no bubble.
            word_next = in_data;
            sel_next  = START_IDX;
          end else begin
            // Frame end, nothing waiting: park the select, keep the word.
            sel_next   = START_IDX;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = START_IDX;
      end
    endcase
  end

  // State, word and select registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
      sel   <= START_IDX;
    end else begin
      state <= state_next;
      word  <= word_next;
      sel   <= sel_next;
    end
  end

endmodule
